host_sequencer: RTL and testbench

HOST_SEQUENCER -- requirements
Module: host_sequencer

---
 rtl/host_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_host_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_sequencer.sv
// ---------------------------------------------------------------------------
// host_sequencer
//
// Moves one block of work between a byte-stream host and a processor that
// shares a data memory with the sequencer:
//   LOAD   : accept LOAD_LEN host bytes and write them to data memory
//            starting at LOAD_BASE.
//   START  : pulse Start for one cycle to kick the processor.
//   WAIT   : wait for a rising edge on Ack, giving up after ACK_TIMEOUT
//            cycles. A timeout raises the sticky Timeout flag and drops
//            the run without unloading.
//   UNLOAD : stream RES_LEN result bytes from data memory starting at
//            RES_BASE to the host.
//
// Ports
//   Clk       in   system clock, rising-edge
//   Reset     in   asynchronous active-low reset
//   InValid   in   host byte available
//   InData    in   [7:0] host byte
//   InReady   out  sequencer accepts host byte this cycle
//   DmWrEn    out  data-memory write strobe
//   DmAddr    out  [7:0] data-memory address (write and read)
//   DmWrData  out  [7:0] data-memory write data
//   DmRdData  in   [7:0] data-memory read data, combinational from DmAddr
//   Start     out  processor start request (flop output)
//   Ack       in   processor done flag
//   OutValid  out  result byte available
//   OutData   out  [7:0] result byte
//   OutReady  in   host accepts result byte
//   Busy      out  run in progress
//   Timeout   out  sticky error: Ack never arrived
//
// The handshake outputs (InReady, DmWrEn, OutValid, DmAddr, OutData) are
// decoded from the state flops and the live handshake inputs so that a
// byte can move on every cycle; Start and Timeout come straight from flops.
// ---------------------------------------------------------------------------
module host_sequencer #(
    parameter logic [7:0] LOAD_BASE   = 8'h00,
    parameter int         LOAD_LEN    = 4,
    parameter logic [7:0] RES_BASE    = 8'h00,
    parameter int         RES_LEN     = 4,
    parameter int         ACK_TIMEOUT = 4096
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       InValid,
    input  logic [7:0] InData,
    output logic       InReady,
    output logic       DmWrEn,
    output logic [7:0] DmAddr,
    output logic [7:0] DmWrData,
    input  logic [7:0] DmRdData,
    output logic       Start,
    input  logic       Ack,
    output logic       OutValid,
    output logic [7:0] OutData,
    input  logic       OutReady,
    output logic       Busy,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // Counters are 9 bits wide so that a length of 256 fits.
    localparam logic [8:0]  LOAD_LAST = 9'(LOAD_LEN - 1);
    localparam logic [8:0]  RES_LAST  = 9'(RES_LEN - 1);
    localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] timer_q, timer_d;
    logic        ack_prev_q, ack_prev_d;
    logic        timeout_q, timeout_d;
    logic        start_q, start_d;

    logic        in_ready_s;
    logic        in_xfer_s;
    logic        out_xfer_s;
    logic        ack_rise_s;

    // Handshake qualifiers. InReady is held low while Reset is asserted so
    // that no write strobe can leak out during reset.
    always_comb begin
        in_ready_s = (state_q == ST_LOAD) && Reset;
        in_xfer_s  = in_ready_s && InValid;
        out_xfer_s = (state_q == ST_UNLOAD) && OutReady;
        // Ack is sampled every cycle in every state, so a level left high
        // from an earlier run never looks like a fresh completion.
        ack_rise_s = Ack && !ack_prev_q;
    end

    // Next-state and next-counter logic for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        start_d    = 1'b0;
        ack_prev_d = Ack;

        case (state_q)
            ST_LOAD: begin
                if (in_xfer_s) begin
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = 9'd0;
                        state_d = ST_START;
                        // Start is registered so it is high exactly while
                        // the FSM sits in START.
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_START: begin
                timer_d = 16'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A rising edge beats a timeout landing on the same cycle.
                if (ack_rise_s) begin
                    idx_d   = 9'd0;
                    timer_d = 16'd0;
                    state_d = ST_UNLOAD;
                end else if (timer_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    timer_d   = 16'd0;
                    state_d   = ST_LOAD;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_UNLOAD: begin
                if (out_xfer_s) begin
                    if (idx_q == RES_LAST) begin
                        idx_d   = 9'd0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            default: begin
                state_d = ST_LOAD;
                cnt_d   = 9'd0;
                idx_d   = 9'd0;
                timer_d = 16'd0;
            end
        endcase
    end

    // State registers; reset abandons any run in progress.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_LOAD;
            cnt_q      <= 9'd0;
            idx_q      <= 9'd0;
            timer_q    <= 16'd0;
            ack_prev_q <= 1'b0;
            timeout_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            ack_prev_q <= ack_prev_d;
            timeout_q  <= timeout_d;
            start_q    <= start_d;
        end
    end

    // Output decode. Addresses are 8-bit sums and wrap from FF to 00.
    // OutData follows DmRdData; the address is held while the host stalls,
    // so the result byte stays stable until it is taken.
    always_comb begin
        InReady  = in_ready_s;
        DmWrEn   = in_xfer_s;
        DmWrData = InData;
        if (state_q == ST_UNLOAD) begin
            DmAddr = RES_BASE + idx_q[7:0];
        end else begin
            DmAddr = LOAD_BASE + cnt_q[7:0];
        end
        OutValid = (state_q == ST_UNLOAD);
        OutData  = DmRdData;
        Busy     = !((state_q == ST_LOAD) && (cnt_q == 9'd0));
        Start    = start_q;
        Timeout  = timeout_q;
    end

endmodule

// File: tb/tb_host_sequencer.sv
module tb_host_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // Instance 1: all defaults.
    logic       in_valid1 = 1'b0;
    logic [7:0] in_data1 = 8'h00;
    logic       in_ready1, dm_wr_en1, start1, out_valid1, busy1, timeout1;
    logic [7:0] dm_addr1, dm_wr_data1, dm_rd_data1, out_data1;
    logic       ack1 = 1'b0;
    logic       out_ready1 = 1'b0;

    // Instance 2: LOAD_BASE=FE, ACK_TIMEOUT=16.
    logic       in_valid2 = 1'b0;
    logic [7:0] in_data2 = 8'h00;
    logic       in_ready2, dm_wr_en2, start2, out_valid2, busy2, timeout2;
    logic [7:0] dm_addr2, dm_wr_data2, dm_rd_data2, out_data2;
    logic       ack2 = 1'b0;
    logic       out_ready2 = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // Data memory read model: address N returns A0+N.
    assign dm_rd_data1 = 8'hA0 + dm_addr1;
    assign dm_rd_data2 = 8'hA0 + dm_addr2;

    always #5 clk = ~clk;

    host_sequencer dut1 (
        .Clk(clk), .Reset(reset_n),
        .InValid(in_valid1), .InData(in_data1), .InReady(in_ready1),
        .DmWrEn(dm_wr_en1), .DmAddr(dm_addr1), .DmWrData(dm_wr_data1),
        .DmRdData(dm_rd_data1), .Start(start1), .Ack(ack1),
        .OutValid(out_valid1), .OutData(out_data1), .OutReady(out_ready1),
        .Busy(busy1), .Timeout(timeout1)
    );

    host_sequencer #(.LOAD_BASE(8'hFE), .ACK_TIMEOUT(16)) dut2 (
        .Clk(clk), .Reset(reset_n),
        .InValid(in_valid2), .InData(in_data2), .InReady(in_ready2),
        .DmWrEn(dm_wr_en2), .DmAddr(dm_addr2), .DmWrData(dm_wr_data2),
        .DmRdData(dm_rd_data2), .Start(start2), .Ack(ack2),
        .OutValid(out_valid2), .OutData(out_data2), .OutReady(out_ready2),
        .Busy(busy2), .Timeout(timeout2)
    );

    // Advance to a point safely after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy1); end
        n_checks++; if (start1 !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b exp 0", start1); end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %b exp 0", out_valid1); end
        n_checks++; if (dm_wr_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b exp 0", dm_wr_en1); end
        n_checks++; if (timeout1 !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout1); end
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_inready got %b exp 1", in_ready1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_rel got %b exp 0", busy1); end
        n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_inready2 got %b exp 1", in_ready2); end
        tick();
    endtask

    // Four bytes with InValid held high, then Start, then WAIT.
    task automatic test_load();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1'b1;
            in_data1 = bytes[i];
            #1;
            n_checks++; if (dm_wr_en1 !== 1'b1) begin n_fail++; $display("FAIL load_wren[%0d] got %b exp 1", i, dm_wr_en1); end
            n_checks++; if (dm_addr1 !== 8'(i)) begin n_fail++; $display("FAIL load_addr[%0d] got %h exp %h", i, dm_addr1, 8'(i)); end
            n_checks++; if (dm_wr_data1 !== bytes[i]) begin n_fail++; $display("FAIL load_data[%0d] got %h exp %h", i, dm_wr_data1, bytes[i]); end
            n_checks++; if (start1 !== 1'b0) begin n_fail++; $display("FAIL load_nostart[%0d] got %b exp 0", i, start1); end
            tick();
        end
        in_data1 = 8'h55;
        #1;
        n_checks++; if (start1 !== 1'b1) begin n_fail++; $display("FAIL start_pulse got %b exp 1", start1); end
        n_checks++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL start_inready got %b exp 0", in_ready1); end
        n_checks++; if (dm_wr_en1 !== 1'b0) begin n_fail++; $display("FAIL start_wren got %b exp 0", dm_wr_en1); end
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b exp 1", busy1); end
        tick();
        n_checks++; if (start1 !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle got %b exp 0", start1); end
        n_checks++; if (dm_wr_en1 !== 1'b0) begin n_fail++; $display("FAIL wait_wren got %b exp 0", dm_wr_en1); end
        in_valid1 = 1'b0;
    endtask

    // Ack after 20 WAIT cycles; four results on consecutive cycles.
    task automatic test_unload();
        for (int k = 0; k < 20; k++) begin
            #1;
            n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL wait_outvalid[%0d] got %b exp 0", k, out_valid1); end
            tick();
        end
        ack1 = 1'b1;
        out_ready1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL unload_valid[%0d] got %b exp 1", i, out_valid1); end
            n_checks++; if (dm_addr1 !== 8'(i)) begin n_fail++; $display("FAIL unload_addr[%0d] got %h exp %h", i, dm_addr1, 8'(i)); end
            n_checks++; if (out_data1 !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL unload_data[%0d] got %h exp %h", i, out_data1, 8'(8'hA0 + i)); end
            tick();
        end
        #1;
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL unload_done_valid got %b exp 0", out_valid1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL unload_done_busy got %b exp 0", busy1); end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL unload_done_inready got %b exp 1", in_ready1); end
        out_ready1 = 1'b0;
    endtask

    // Ack still high from the last run: must fall and rise again.
    // Host bytes offered during WAIT must be ignored.
    task automatic test_ack_held();
        in_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data1 = 8'(8'h60 + i);
            tick();
        end
        #1;
        n_checks++; if (start1 !== 1'b1) begin n_fail++; $display("FAIL held_start got %b exp 1", start1); end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL held_outvalid[%0d] got %b exp 0", k, out_valid1); end
            n_checks++; if (dm_wr_en1 !== 1'b0) begin n_fail++; $display("FAIL held_wren[%0d] got %b exp 0", k, dm_wr_en1); end
            n_checks++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL held_inready[%0d] got %b exp 0", k, in_ready1); end
            tick();
        end
        in_valid1 = 1'b0;
        ack1 = 1'b0;
        #1;
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL held_fall got %b exp 0", out_valid1); end
        tick();
        ack1 = 1'b1;
        tick();
        #1;
        n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL held_rise got %b exp 1", out_valid1); end
    endtask

    // Stall the host for 5 cycles on the second result byte.
    task automatic test_stall();
        out_ready1 = 1'b1;
        #1;
        n_checks++; if (out_data1 !== 8'hA0) begin n_fail++; $display("FAIL stall_b0 got %h exp a0", out_data1); end
        tick();
        out_ready1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", k, out_valid1); end
            n_checks++; if (out_data1 !== 8'hA1) begin n_fail++; $display("FAIL stall_data[%0d] got %h exp a1", k, out_data1); end
            tick();
        end
        out_ready1 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_checks++; if (out_data1 !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL stall_resume[%0d] got %h exp %h", i, out_data1, 8'(8'hA0 + i)); end
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL stall_resume_valid[%0d] got %b exp 1", i, out_valid1); end
            tick();
        end
        #1;
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got %b exp 0", out_valid1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL stall_end_busy got %b exp 0", busy1); end
        n_checks++; if (timeout1 !== 1'b0) begin n_fail++; $display("FAIL dut1_timeout got %b exp 0", timeout1); end
        out_ready1 = 1'b0;
    endtask

    // LOAD_BASE=FE wraps; ACK_TIMEOUT=16 fires 16 cycles into WAIT.
    task automatic test_wrap_timeout();
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        in_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data2 = 8'(8'hC0 + i);
            #1;
            n_checks++; if (dm_addr2 !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, dm_addr2, exp_addr[i]); end
            n_checks++; if (dm_wr_en2 !== 1'b1) begin n_fail++; $display("FAIL wrap_wren[%0d] got %b exp 1", i, dm_wr_en2); end
            tick();
        end
        in_valid2 = 1'b0;
        #1;
        n_checks++; if (start2 !== 1'b1) begin n_fail++; $display("FAIL tmo_start got %b exp 1", start2); end
        tick();
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++; if (timeout2 !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d] got %b exp 0", k, timeout2); end
            n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL tmo_outvalid[%0d] got %b exp 0", k, out_valid2); end
            tick();
        end
        #1;
        n_checks++; if (timeout2 !== 1'b1) begin n_fail++; $display("FAIL tmo_set got %b exp 1", timeout2); end
        n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL tmo_inready got %b exp 1", in_ready2); end
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL tmo_no_unload got %b exp 0", out_valid2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b exp 0", busy2); end
    endtask

    // Second run: Timeout stays set; Ack rise on the timeout cycle wins.
    task automatic test_timeout_tie();
        in_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data2 = 8'(8'hD0 + i);
            tick();
        end
        in_valid2 = 1'b0;
        tick();
        #1;
        n_checks++; if (timeout2 !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b exp 1", timeout2); end
        for (int k = 0; k < 15; k++) tick();
        ack2 = 1'b1;
        out_ready2 = 1'b1;
        #1;
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL tie_pre got %b exp 0", out_valid2); end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL tie_valid[%0d] got %b exp 1", i, out_valid2); end
            n_checks++; if (out_data2 !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL tie_data[%0d] got %h exp %h", i, out_data2, 8'(8'hA0 + i)); end
            tick();
        end
        #1;
        n_checks++; if (timeout2 !== 1'b1) begin n_fail++; $display("FAIL tie_timeout got %b exp 1", timeout2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL tie_busy got %b exp 0", busy2); end
        ack2 = 1'b0;
        out_ready2 = 1'b0;
    endtask

    // Reset after two bytes: immediate reset outputs, full reload needed.
    task automatic test_reset_midrun();
        ack1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1 = 8'h77;
        tick();
        tick();
        #1;
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy1); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy1); end
        n_checks++; if (dm_wr_en1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wren got %b exp 0", dm_wr_en1); end
        n_checks++; if (dm_addr1 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_addr got %h exp 00", dm_addr1); end
        n_checks++; if (timeout2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_timeout got %b exp 0", timeout2); end
        tick();
        reset_n = 1'b1;
        in_valid1 = 1'b0;
        #1;
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL mid_rel_inready got %b exp 1", in_ready1); end
        in_valid1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (dm_addr1 !== 8'(i)) begin n_fail++; $display("FAIL reload_addr[%0d] got %h exp %h", i, dm_addr1, 8'(i)); end
            tick();
        end
        in_valid1 = 1'b0;
        #1;
        n_checks++; if (start1 !== 1'b0) begin n_fail++; $display("FAIL reload_early_start got %b exp 0", start1); end
        n_checks++; if (dm_addr1 !== 8'h03) begin n_fail++; $display("FAIL reload_addr3 got %h exp 03", dm_addr1); end
        tick();
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        #1;
        n_checks++; if (start1 !== 1'b1) begin n_fail++; $display("FAIL reload_start got %b exp 1", start1); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_unload();
        test_ack_held();
        test_stall();
        test_wrap_timeout();
        test_timeout_tie();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
